// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and the datapath, the instruction memory and the PC register.
// The sequencer side is the master; the datapath/register side is the slave.
interface pc_sequencer_if;
  logic [7:0] pc_atual;
  logic       mem_ack;
  logic       exec_done;
  logic       desvio;
  logic [7:0] alvo;
  logic       parar;
  logic       irq;
  logic [7:0] EntradaPC;
  logic       EscPC;
  logic       mem_req;
  logic       EscIR;
  logic       exec_start;
  logic [7:0] epc;
  logic       halted;
  logic       err;
  logic [2:0] estado;

  modport master (
    input  pc_atual, mem_ack, exec_done, desvio, alvo, parar, irq,
    output EntradaPC, EscPC, mem_req, EscIR, exec_start, epc, halted, err, estado
  );

  modport slave (
    output pc_atual, mem_ack, exec_done, desvio, alvo, parar, irq,
    input  EntradaPC, EscPC, mem_req, EscIR, exec_start, epc, halted, err, estado
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute/update controller that owns the PC register write port.
// Chooses the next PC from the sequential, branch or interrupt-vector source and handles halt and fetch timeout.
module pc_sequencer #(
  parameter logic [7:0]  RESET_VEC   = 8'h00,
  parameter logic [7:0]  IRQ_VEC     = 8'hF0,
  parameter logic [7:0]  PC_STEP     = 8'd1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       irq_pend_q, irq_pend_d;
  logic       desvio_q, desvio_d;
  logic [7:0] alvo_q, alvo_d;
  logic       parar_q, parar_d;
  logic       from_halt_q, from_halt_d;
  logic       exec_first_q, exec_first_d;
  logic [7:0] epc_q, epc_d;

  logic [7:0] seq_pc;
  logic [7:0] normal_pc;
  logic [7:0] entrada_c;
  logic       escpc_c;
  logic       taken;

  always_comb begin
    seq_pc       = bus.pc_atual + PC_STEP;
    normal_pc    = desvio_q ? alvo_q : seq_pc;
    state_d      = state_q;
    cnt_d        = cnt_q;
    desvio_d     = desvio_q;
    alvo_d       = alvo_q;
    parar_d      = parar_q;
    from_halt_d  = from_halt_q;
    exec_first_d = exec_first_q;
    epc_d        = epc_q;
    escpc_c      = 1'b0;
    entrada_c    = bus.pc_atual;
    taken        = 1'b0;

    case (state_q)
      S_INIT: begin
        escpc_c   = 1'b1;
        entrada_c = RESET_VEC;
        cnt_d     = 8'd0;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (bus.mem_ack) begin
          cnt_d        = 8'd0;
          exec_first_d = 1'b1;
          state_d      = S_EXEC;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        exec_first_d = 1'b0;
        if (bus.exec_done) begin
          desvio_d    = bus.desvio;
          alvo_d      = bus.alvo;
          parar_d     = bus.parar;
          from_halt_d = 1'b0;
          state_d     = S_UPDATE;
        end
      end
      S_UPDATE: begin
        from_halt_d = 1'b0;
        if (parar_q) begin
          state_d = S_HALT;
        end else begin
          escpc_c = 1'b1;
          state_d = S_FETCH;
          if (irq_pend_q) begin
            taken     = 1'b1;
            entrada_c = IRQ_VEC;
            // Leaving HALT there is no instruction to complete, so return to the halted PC.
            epc_d     = from_halt_q ? bus.pc_atual : normal_pc;
          end else begin
            entrada_c = normal_pc;
          end
        end
      end
      S_HALT: begin
        if (irq_pend_q) begin
          parar_d     = 1'b0;
          from_halt_d = 1'b1;
          state_d     = S_UPDATE;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // A fresh irq arriving in the cycle the pending one is taken re-arms it.
    irq_pend_d = (irq_pend_q & ~taken) | bus.irq;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      cnt_q        <= 8'd0;
      irq_pend_q   <= 1'b0;
      desvio_q     <= 1'b0;
      alvo_q       <= 8'd0;
      parar_q      <= 1'b0;
      from_halt_q  <= 1'b0;
      exec_first_q <= 1'b0;
      epc_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      irq_pend_q   <= irq_pend_d;
      desvio_q     <= desvio_d;
      alvo_q       <= alvo_d;
      parar_q      <= parar_d;
      from_halt_q  <= from_halt_d;
      exec_first_q <= exec_first_d;
      epc_q        <= epc_d;
    end
  end

  // Every output is forced low while reset is held, including the INIT write strobe.
  assign bus.EscPC      = ~reset & escpc_c;
  assign bus.EntradaPC  = reset ? 8'd0 : entrada_c;
  assign bus.mem_req    = ~reset & (state_q == S_FETCH);
  assign bus.EscIR      = ~reset & (state_q == S_FETCH) & bus.mem_ack;
  assign bus.exec_start = ~reset & (state_q == S_EXEC) & exec_first_q;
  assign bus.epc        = reset ? 8'd0 : epc_q;
  assign bus.halted     = ~reset & (state_q == S_HALT);
  assign bus.err        = ~reset & (state_q == S_ERROR);
  assign bus.estado     = reset ? 3'd0 : state_q;

endmodule
